// File: rtl/reg_wr_arb_4mb.sv
// Register-bank write-port arbiter: posted SPI writes buffered in a FIFO,
// internal writes via req/ack. Round-robin on ties, optional post-write gap.
module reg_wr_arb_4mb #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk_100m,
    input  logic                          rst_n_syn,
    input  logic [AW-1:0]                 spi_addr,
    input  logic [DW-1:0]                 spi_data,
    input  logic                          spi_wr_vld,
    input  logic [AW-1:0]                 int_addr,
    input  logic [DW-1:0]                 int_data,
    input  logic                          int_wr_req,
    output logic                          int_wr_ack,
    input  logic                          ovf_clr,
    output logic [AW-1:0]                 addr,
    output logic [DW-1:0]                 data_mosi,
    output logic                          data_mosi_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          spi_ovf,
    output logic [1:0]                    state_dbg
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_GAP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              last_int_q, last_int_d;
    logic              gnt_int_q, gnt_int_d;
    logic [AW+DW-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;

    logic spi_pend, fifo_full, gnt_spi, gnt_int, push, pop, ovf_evt;

    assign spi_pend  = (level_q != '0);
    assign fifo_full = (level_q == FULL_LVL);

    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Tie-break: SPI wins unless it was the last grant, so reset (last=INT) favours SPI.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        gnt_spi   = 1'b0;
        gnt_int   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (spi_pend && (!int_wr_req || last_int_q)) begin
                    gnt_spi = 1'b1;
                end else if (int_wr_req) begin
                    gnt_int = 1'b1;
                end
                if (gnt_spi || gnt_int) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                gap_cnt_d = '0;
                state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_mosi_rdy = (state_q == S_ISSUE);
        int_wr_ack    = (state_q == S_ISSUE) && gnt_int_q;
        state_dbg     = state_q;
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    always_comb begin
        pop        = gnt_spi;
        push       = spi_wr_vld && (!fifo_full || pop);
        ovf_evt    = spi_wr_vld && fifo_full && !pop;
        level_d    = level_q + LW'(push) - LW'(pop);
        ovf_d      = ovf_evt | (ovf_q & ~ovf_clr);
        last_int_d = gnt_int ? 1'b1 : (gnt_spi ? 1'b0 : last_int_q);
        gnt_int_d  = (gnt_spi || gnt_int) ? gnt_int : gnt_int_q;
        addr_d     = addr_q;
        data_d     = data_q;
        if (gnt_spi) begin
            {addr_d, data_d} = mem_q[rd_ptr_q];
        end else if (gnt_int) begin
            addr_d = int_addr;
            data_d = int_data;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            last_int_q <= 1'b1;
            gnt_int_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            last_int_q <= last_int_d;
            gnt_int_q  <= gnt_int_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (push) mem_q[wr_ptr_q] <= {spi_addr, spi_data};
    end

    assign addr       = addr_q;
    assign data_mosi  = data_q;
    assign fifo_level = level_q;
    assign spi_ovf    = ovf_q;
endmodule
